// File: rtl/display_pkg.sv
// Shared constants and state encoding for the pixel write path
// in front of the 32x32 panel driver.
package display_pkg;

    localparam int ADDR_W     = 10;
    localparam int COLOR_W    = 24;
    localparam int NUM_PIXELS = 1024;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request
// searching upward from ptr+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin : pick
        logic             found;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the panel driver's pixel write port between NUM_REQ sources,
// with a full-screen clear sequencer and best_write_time sync gating.
module pixel_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = display_pkg::ADDR_W,
    parameter int COLOR_W = display_pkg::COLOR_W,
    parameter int WINDOW  = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       clear_start,
    input  logic [COLOR_W-1:0]         clear_color,
    output logic                       clear_busy,
    input  logic                       sync_mode,
    input  logic                       best_write_time,
    output logic [ADDR_W-1:0]          write_address,
    output logic [COLOR_W-1:0]         write_color,
    output logic                       write_enable
);

    import display_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WIN_W = $clog2(WINDOW + 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [WIN_W-1:0]   win_cnt;
    logic               open_win;
    logic               arb_en;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [COLOR_W-1:0] sel_color;

    assign open_win = !sync_mode || (win_cnt != '0);
    assign arb_en   = !reset && (state == IDLE)
                      && open_win && !clear_start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    always_comb begin
        sel_addr  = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Runs even when sync_mode is off so toggling it mid-frame is seamless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (best_write_time) begin
            win_cnt <= WIN_W'(WINDOW);
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    // During CLEAR the write_address register doubles as the sweep counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            clear_busy    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_color   <= '0;
            ptr           <= IDX_W'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state         <= CLEAR;
                        clear_busy    <= 1'b1;
                        write_enable  <= 1'b1;
                        write_address <= '0;
                        write_color   <= clear_color;
                    end else if (transfer) begin
                        write_enable  <= 1'b1;
                        write_address <= sel_addr;
                        write_color   <= sel_color;
                        ptr           <= grant_idx;
                    end else begin
                        write_enable  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (write_address == '1) begin
                        state        <= IDLE;
                        clear_busy   <= 1'b0;
                        write_enable <= 1'b0;
                    end else begin
                        write_address <= write_address + 1'b1;
                        write_enable  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
